e203_ifu_flush_redirect: RTL and testbench

- IFU-side consumer of the EXU commit stage's pipeline-flush request.
- Computes the flush target from op1+op2 and acknowledges every flush.
- Discards fetch responses still in flight from the abandoned path, then issues the first fetch at the target and tells the PC generator to resume there.
- Sits between the IFU sequential PC generator and the instruction-fetch bus port.

---
 rtl/e203_ifu_flush_redirect_if.sv | 27 ++
 rtl/e203_ifu_flush_redirect.sv | 130 +++++++++++++
 tb/tb_e203_ifu_flush_redirect.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/e203_ifu_flush_redirect_if.sv
// Instruction-fetch bus port between the flush/redirect unit and the bus.
// Requests are valid/ready; responses return in order and are always accepted.
interface e203_ifu_flush_redirect_if #(
  parameter int PC_SIZE = 32
);
  logic               ifu_req_valid;
  logic [PC_SIZE-1:0] ifu_req_pc;
  logic               ifu_req_ready;
  logic               ifu_rsp_valid;
  logic               ifu_rsp_ready;

  modport master (
    output ifu_req_valid,
    output ifu_req_pc,
    input  ifu_req_ready,
    input  ifu_rsp_valid,
    output ifu_rsp_ready
  );

  modport slave (
    input  ifu_req_valid,
    input  ifu_req_pc,
    output ifu_req_ready,
    output ifu_rsp_valid,
    input  ifu_rsp_ready
  );
endinterface

// File: rtl/e203_ifu_flush_redirect.sv
// IFU flush consumer: drops in-flight old-path responses, fetches the target.
// Optional E203_FLUSH_DRAIN_BYPASS_EN issues the target without draining.
module e203_ifu_flush_redirect #(
  parameter int PC_SIZE    = 32,
  parameter int OUTS_DEPTH = 2,
  parameter int CNT_W      = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pipe_flush_req,
  output logic               pipe_flush_ack,
  input  logic [PC_SIZE-1:0] pipe_flush_add_op1,
  input  logic [PC_SIZE-1:0] pipe_flush_add_op2,
  input  logic               seq_req_valid,
  input  logic [PC_SIZE-1:0] seq_req_pc,
  output logic               seq_req_ready,
  e203_ifu_flush_redirect_if.master bus,
  output logic               rsp_pass_valid,
  output logic               rsp_drop,
  output logic               redirect_vld,
  output logic [PC_SIZE-1:0] redirect_pc,
  output logic [CNT_W-1:0]   outs_cnt
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] ISSUE = 2'd2;

  logic [1:0]         state;
  logic [1:0]         state_nxt;
  logic [CNT_W-1:0]   drop_cnt;
  logic [CNT_W-1:0]   drop_nxt;
  logic [CNT_W-1:0]   outs_nxt;
  logic [PC_SIZE-1:0] target;
  logic [PC_SIZE-1:0] tgt_sum;
  logic               flush;
  logic               rsp_hit;
  logic               req_hsk;
  logic               at_depth;
  logic               drop_now;

  assign pipe_flush_ack    = 1'b1;
  assign flush             = pipe_flush_req & pipe_flush_ack;
  assign tgt_sum           = pipe_flush_add_op1 + pipe_flush_add_op2;
  assign at_depth          = (outs_cnt == CNT_W'(OUTS_DEPTH));
  assign rsp_hit           = bus.ifu_rsp_valid & (outs_cnt != '0);
  assign bus.ifu_rsp_ready = 1'b1;

  always_comb begin
    bus.ifu_req_valid = 1'b0;
    bus.ifu_req_pc    = seq_req_pc;
    seq_req_ready     = 1'b0;
    if (!flush) begin
      unique case (1'b1)
        (state == IDLE): begin
          bus.ifu_req_valid = seq_req_valid & ~at_depth;
          seq_req_ready     = bus.ifu_req_ready & ~at_depth;
        end
        (state == ISSUE): begin
          bus.ifu_req_valid = ~at_depth;
          bus.ifu_req_pc    = target;
        end
        default: ;
      endcase
    end
  end

  assign req_hsk      = bus.ifu_req_valid & bus.ifu_req_ready;
  assign redirect_vld = (state == ISSUE) & req_hsk;
  assign redirect_pc  = target;

  // A flush-cycle response belongs to the abandoned path as well
  assign drop_now       = bus.ifu_rsp_valid & (flush | (drop_cnt != '0));
  assign rsp_drop       = drop_now;
  assign rsp_pass_valid = bus.ifu_rsp_valid & ~drop_now;

  always_comb begin
    outs_nxt = outs_cnt;
    unique case ({req_hsk, rsp_hit})
      2'b10:   outs_nxt = outs_cnt + 1'b1;
      2'b01:   outs_nxt = outs_cnt - 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    drop_nxt = drop_cnt;
    if (flush)
      drop_nxt = outs_cnt - CNT_W'(rsp_hit);
    else if (drop_now)
      drop_nxt = drop_cnt - 1'b1;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
`ifdef E203_FLUSH_DRAIN_BYPASS_EN
      state_nxt = ISSUE;
`else
      state_nxt = (drop_nxt != '0) ? DRAIN : ISSUE;
`endif
    end else begin
      unique case (1'b1)
        (state == DRAIN):
          if (bus.ifu_rsp_valid && drop_cnt == CNT_W'(1))
            state_nxt = ISSUE;
        (state == ISSUE):
          if (req_hsk)
            state_nxt = IDLE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      outs_cnt <= '0;
      drop_cnt <= '0;
      target   <= '0;
    end else begin
      state    <= state_nxt;
      outs_cnt <= outs_nxt;
      drop_cnt <= drop_nxt;
      if (flush)
        target <= {tgt_sum[PC_SIZE-1:1], 1'b0};
    end
  end

endmodule

// File: tb/tb_e203_ifu_flush_redirect.sv
// Directed bench for e203_ifu_flush_redirect (default build, drain enabled).
// Inputs change 1ns after posedge; outputs are sampled 1ns later.
module tb_e203_ifu_flush_redirect;
  localparam int PC_SIZE = 32;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               pipe_flush_req;
  logic               pipe_flush_ack;
  logic [PC_SIZE-1:0] op1;
  logic [PC_SIZE-1:0] op2;
  logic               seq_req_valid;
  logic [PC_SIZE-1:0] seq_req_pc;
  logic               seq_req_ready;
  logic               rsp_pass_valid;
  logic               rsp_drop;
  logic               redirect_vld;
  logic [PC_SIZE-1:0] redirect_pc;
  logic [1:0]         outs_cnt;

  int checks = 0;
  int failures = 0;

  e203_ifu_flush_redirect_if #(.PC_SIZE(PC_SIZE)) bus ();

  e203_ifu_flush_redirect #(
    .PC_SIZE(PC_SIZE), .OUTS_DEPTH(2), .CNT_W(2)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .pipe_flush_req     (pipe_flush_req),
    .pipe_flush_ack     (pipe_flush_ack),
    .pipe_flush_add_op1 (op1),
    .pipe_flush_add_op2 (op2),
    .seq_req_valid      (seq_req_valid),
    .seq_req_pc         (seq_req_pc),
    .seq_req_ready      (seq_req_ready),
    .bus                (bus.master),
    .rsp_pass_valid     (rsp_pass_valid),
    .rsp_drop           (rsp_drop),
    .redirect_vld       (redirect_vld),
    .redirect_pc        (redirect_pc),
    .outs_cnt           (outs_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    pipe_flush_req = 1'b0;
    op1 = '0;
    op2 = '0;
    seq_req_valid = 1'b0;
    seq_req_pc = '0;
    bus.ifu_req_ready = 1'b0;
    bus.ifu_rsp_valid = 1'b0;
    repeat (2) step();
    settle();
    chk("rst_ack", pipe_flush_ack, 1);
    chk("rst_redir", redirect_vld, 0);
    chk("rst_outs", outs_cnt, 0);
    chk("rst_reqv", bus.ifu_req_valid, 0);
    chk("rst_rspr", bus.ifu_rsp_ready, 1);
    rst_n = 1'b1;
    step();

    // idle flush
    pipe_flush_req = 1'b1;
    op1 = 32'h8000_0000;
    op2 = 32'h0000_0103;
    settle();
    chk("if_ack", pipe_flush_ack, 1);
    chk("if_reqv0", bus.ifu_req_valid, 0);
    step();
    pipe_flush_req = 1'b0;
    settle();
    chk("if_reqv1", bus.ifu_req_valid, 1);
    chk("if_pc", bus.ifu_req_pc, 32'h8000_0102);
    chk("if_redir0", redirect_vld, 0);
    chk("if_seqr", seq_req_ready, 0);
    bus.ifu_req_ready = 1'b1;
    settle();
    chk("if_redir1", redirect_vld, 1);
    chk("if_rpc", redirect_pc, 32'h8000_0102);
    step();
    bus.ifu_req_ready = 1'b0;
    settle();
    chk("if_redir2", redirect_vld, 0);
    chk("if_idle", bus.ifu_req_valid, 0);
    chk("if_outs", outs_cnt, 1);
    bus.ifu_rsp_valid = 1'b1;
    settle();
    chk("if_pass", rsp_pass_valid, 1);
    chk("if_nodrop", rsp_drop, 0);
    step();
    settle();
    chk("sat_outs0", outs_cnt, 0);
    step();
    bus.ifu_rsp_valid = 1'b0;
    settle();
    chk("sat_outs1", outs_cnt, 0);

    // depth limit then drain
    seq_req_valid = 1'b1;
    seq_req_pc = 32'h1000;
    bus.ifu_req_ready = 1'b1;
    settle();
    chk("seq_v", bus.ifu_req_valid, 1);
    chk("seq_pc", bus.ifu_req_pc, 32'h1000);
    chk("seq_rdy", seq_req_ready, 1);
    step();
    seq_req_pc = 32'h1004;
    step();
    settle();
    chk("dep_outs", outs_cnt, 2);
    chk("dep_v", bus.ifu_req_valid, 0);
    chk("dep_rdy", seq_req_ready, 0);
    step();
    chk("dep_outs2", outs_cnt, 2);
    pipe_flush_req = 1'b1;
    op1 = 32'h2000;
    op2 = 32'h0010;
    settle();
    chk("dr_fv", bus.ifu_req_valid, 0);
    chk("dr_frdy", seq_req_ready, 0);
    step();
    pipe_flush_req = 1'b0;
    seq_req_valid = 1'b0;
    settle();
    chk("dr_v0", bus.ifu_req_valid, 0);
    bus.ifu_rsp_valid = 1'b1;
    settle();
    chk("dr_drop1", rsp_drop, 1);
    chk("dr_pass1", rsp_pass_valid, 0);
    step();
    settle();
    chk("dr_drop2", rsp_drop, 1);
    chk("dr_v1", bus.ifu_req_valid, 0);
    step();
    bus.ifu_rsp_valid = 1'b0;
    settle();
    chk("dr_iv", bus.ifu_req_valid, 1);
    chk("dr_ipc", bus.ifu_req_pc, 32'h2010);
    chk("dr_redir", redirect_vld, 1);
    step();
    bus.ifu_req_ready = 1'b0;
    bus.ifu_rsp_valid = 1'b1;
    settle();
    chk("dr_tpass", rsp_pass_valid, 1);
    chk("dr_tdrop", rsp_drop, 0);
    step();
    bus.ifu_rsp_valid = 1'b0;

    // response in the flush cycle
    seq_req_valid = 1'b1;
    seq_req_pc = 32'h3000;
    bus.ifu_req_ready = 1'b1;
    step();
    seq_req_valid = 1'b0;
    bus.ifu_req_ready = 1'b0;
    settle();
    chk("rf_outs", outs_cnt, 1);
    pipe_flush_req = 1'b1;
    op1 = 32'h4000;
    op2 = 32'h0001;
    bus.ifu_rsp_valid = 1'b1;
    settle();
    chk("rf_drop", rsp_drop, 1);
    chk("rf_pass", rsp_pass_valid, 0);
    step();
    pipe_flush_req = 1'b0;
    bus.ifu_rsp_valid = 1'b0;
    settle();
    chk("rf_iv", bus.ifu_req_valid, 1);
    chk("rf_pc", bus.ifu_req_pc, 32'h4000);
    chk("rf_outs0", outs_cnt, 0);
    bus.ifu_req_ready = 1'b1;
    step();
    bus.ifu_req_ready = 1'b0;
    bus.ifu_rsp_valid = 1'b1;
    step();
    bus.ifu_rsp_valid = 1'b0;

    // back-to-back flush
    pipe_flush_req = 1'b1;
    op1 = 32'h100;
    op2 = 32'h0;
    step();
    pipe_flush_req = 1'b0;
    settle();
    chk("bb_pc1", bus.ifu_req_pc, 32'h100);
    pipe_flush_req = 1'b1;
    op1 = 32'h200;
    bus.ifu_req_ready = 1'b1;
    settle();
    chk("bb_v", bus.ifu_req_valid, 0);
    chk("bb_redir0", redirect_vld, 0);
    step();
    pipe_flush_req = 1'b0;
    settle();
    chk("bb_outs", outs_cnt, 0);
    chk("bb_pc2", bus.ifu_req_pc, 32'h200);
    chk("bb_redir1", redirect_vld, 1);
    chk("bb_rpc", redirect_pc, 32'h200);
    step();
    bus.ifu_req_ready = 1'b0;
    settle();
    chk("bb_redir2", redirect_vld, 0);
    chk("bb_outs1", outs_cnt, 1);
    bus.ifu_rsp_valid = 1'b1;
    step();
    bus.ifu_rsp_valid = 1'b0;

    // async reset while draining
    seq_req_valid = 1'b1;
    seq_req_pc = 32'h5000;
    bus.ifu_req_ready = 1'b1;
    repeat (2) step();
    pipe_flush_req = 1'b1;
    op1 = 32'h6000;
    step();
    pipe_flush_req = 1'b0;
    settle();
    chk("ar_drain", bus.ifu_req_valid, 0);
    #2;
    rst_n = 1'b0;
    settle();
    chk("ar_outs", outs_cnt, 0);
    chk("ar_redir", redirect_vld, 0);
    chk("ar_idle", bus.ifu_req_valid, 1);
    bus.ifu_rsp_valid = 1'b1;
    settle();
    chk("ar_pass", rsp_pass_valid, 1);
    chk("ar_drop", rsp_drop, 0);
    step();
    bus.ifu_rsp_valid = 1'b0;
    seq_req_valid = 1'b0;
    rst_n = 1'b1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
